// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin arbiter sharing one 8-bit APB master port
// Sequences SETUP/ACCESS phases, handles wait states and aborts stalled transfers.
module apb_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_write,
  input  logic [8*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [7:0]           paddr,
  output logic [7:0]           pwdata,
  input  logic [7:0]           prdata,
  input  logic                 pready,
  input  logic                 pslverr
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_COMPLETE} state_t;

  state_t        state;
  logic [IW-1:0] rr;
  logic [IW-1:0] gidx;
  logic [CW-1:0] wait_cnt;
  logic [IW-1:0] pick;
  logic          pick_vld;
  int            idx;

  // Scan offsets from the highest down so the lowest offset from rr wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[IW'(idx)]) begin
        pick     = IW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= S_IDLE;
      rr        <= '0;
      gidx      <= '0;
      wait_cnt  <= '0;
      gnt       <= '0;
      done      <= '0;
      rsp_rdata <= 8'h00;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= 8'h00;
      pwdata    <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            gidx     <= pick;
            gnt      <= ONE << pick;
            pwrite   <= req_write[pick];
            paddr    <= req_addr[8*pick +: 8];
            pwdata   <= req_wdata[8*pick +: 8];
            psel     <= 1'b1;
            penable  <= 1'b0;
            busy     <= 1'b1;
            wait_cnt <= '0;
            state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable <= 1'b1;
          state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready) begin
            rsp_rdata <= pwrite ? 8'h00 : prdata;
            rsp_err   <= pslverr;
            psel      <= 1'b0;
            penable   <= 1'b0;
            done      <= gnt;
            state     <= S_COMPLETE;
          end else if (TIMEOUT_CYCLES != 0 && wait_cnt == TO_LAST) begin
            // This edge is the TIMEOUT_CYCLES-th stalled ACCESS cycle.
            rsp_rdata <= 8'h00;
            rsp_err   <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            done      <= gnt;
            state     <= S_COMPLETE;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_COMPLETE: begin
          done  <= '0;
          gnt   <= '0;
          busy  <= 1'b0;
          rr    <= (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + IW'(1);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - scoreboard bench for apb_master_arbiter
module tb_apb_master_arbiter;
  localparam int N = 4;

  logic           pclk = 1'b0;
  logic           presetn;
  logic [N-1:0]   req, req_write;
  logic [8*N-1:0] req_addr, req_wdata;
  logic [N-1:0]   gnt, done;
  logic [7:0]     rsp_rdata;
  logic           rsp_err, busy, psel, penable, pwrite;
  logic [7:0]     paddr, pwdata, prdata;
  logic           pready, pslverr;

  always #5 pclk = ~pclk;

  apb_master_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(8)) dut (
    .pclk(pclk), .presetn(presetn), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .psel(psel),
    .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct {
    int         idx;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       err;
    int         acc;
    int         gap;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   total = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic push_exp(input int i, input logic wr, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] rd, input logic err, input int acc, input int gap);
    exp_t e;
    e.idx = i; e.wr = wr; e.addr = a; e.wdata = d;
    e.rdata = rd; e.err = err; e.acc = acc; e.gap = gap;
    sbq.push_back(e);
  endtask

  task automatic set_req(input int i, input logic wr, input logic [7:0] a, input logic [7:0] d);
    req_write[i]      = wr;
    req_addr[8*i +: 8]  = a;
    req_wdata[8*i +: 8] = d;
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge pclk);
      if (done != '0) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      $display("FAIL %s: no done within 60 cycles, required a done pulse", name);
    end
  endtask

  // APB slave model: programmable wait states, stall, and bus-stability tracking
  int         wait_n = 0;
  bit         stuck = 1'b0;
  logic       slv_err = 1'b0;
  int         acc_cnt = 0;
  int         last_acc = 0;
  logic [7:0] seen_addr, seen_wdata;
  logic       seen_wr;
  logic       bus_changed = 1'b0;

  always @(negedge pclk) begin
    if (psel && penable) begin
      if (acc_cnt == 0) begin
        seen_addr = paddr; seen_wdata = pwdata; seen_wr = pwrite; bus_changed = 1'b0;
      end else if (paddr !== seen_addr || pwdata !== seen_wdata || pwrite !== seen_wr) begin
        bus_changed = 1'b1;
      end
      acc_cnt++;
    end else begin
      if (acc_cnt != 0) last_acc = acc_cnt;
      acc_cnt = 0;
    end
    pready  = !stuck && (acc_cnt > wait_n);
    prdata  = paddr ^ 8'hB5;
    pslverr = slv_err;
  end

  int cyc = 0;
  int last_done = 0;
  always @(posedge pclk) cyc++;

  always @(negedge pclk) begin
    #1;
    if (presetn === 1'b1 && done != '0) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("done_onehot", 32'(done), 32'd1 << mon_e.idx);
        chk("gnt_held", 32'(gnt), 32'(done));
        chk("busy_complete", 32'(busy), 32'd1);
        chk("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
        chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        chk("bus_addr", 32'(seen_addr), 32'(mon_e.addr));
        chk("bus_write", 32'(seen_wr), 32'(mon_e.wr));
        if (mon_e.wr) chk("bus_wdata", 32'(seen_wdata), 32'(mon_e.wdata));
        chk("bus_stable", 32'(bus_changed), 32'd0);
        chk("access_cycles", 32'(last_acc), 32'(mon_e.acc));
        if (mon_e.gap != 0) chk("done_spacing", 32'(cyc - last_done), 32'(mon_e.gap));
      end
      last_done = cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw;
    presetn = 1'b0; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge pclk);
    chk("rst_ctl", 32'({psel, penable, pwrite, busy, rsp_err, gnt, done}), 32'd0);
    chk("rst_data", 32'({paddr, pwdata, rsp_rdata}), 32'd0);
    presetn = 1'b1;
    @(negedge pclk);

    // all requesters held: grant order 0,1,2,3,0 with 4 cycles per transfer
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'h20 + 8'(i), 8'h00);
    push_exp(0, 0, 8'h20, 8'h00, 8'h95, 0, 1, 0);
    push_exp(1, 0, 8'h21, 8'h00, 8'h94, 0, 1, 4);
    push_exp(2, 0, 8'h22, 8'h00, 8'h97, 0, 1, 4);
    push_exp(3, 0, 8'h23, 8'h00, 8'h96, 0, 1, 4);
    push_exp(0, 0, 8'h20, 8'h00, 8'h95, 0, 1, 4);
    req = 4'hF;
    for (int n = 0; n < 5; n++) wait_done("rr_all");
    req = '0;
    repeat (2) @(negedge pclk);

    // single read, zero wait states, phase timing
    set_req(0, 1'b0, 8'h10, 8'h00);
    push_exp(0, 0, 8'h10, 8'h00, 8'hA5, 0, 1, 0);
    req = 4'b0001;
    @(negedge pclk);
    chk("t1_setup_phase", 32'({psel, penable, gnt}), 32'b10_0001);
    @(negedge pclk);
    chk("t1_access_phase", 32'({psel, penable}), 32'b11);
    @(negedge pclk);
    chk("t1_done_latency", 32'(done), 32'b0001);
    req = '0;
    repeat (2) @(negedge pclk);

    // write with two wait states and slave error
    set_req(2, 1'b1, 8'h3C, 8'h5A);
    wait_n = 2; slv_err = 1'b1;
    push_exp(2, 1, 8'h3C, 8'h5A, 8'h00, 1, 3, 0);
    req = 4'b0100;
    wait_done("t2_write_err");
    req = '0; wait_n = 0; slv_err = 1'b0;
    repeat (2) @(negedge pclk);

    // stalled read aborted after 8 ACCESS wait cycles
    set_req(0, 1'b0, 8'h44, 8'h00);
    stuck = 1'b1;
    push_exp(0, 0, 8'h44, 8'h00, 8'h00, 1, 8, 0);
    req = 4'b0001;
    wait_done("t4_timeout");
    chk("t4_psel_dropped", 32'({psel, penable}), 32'd0);
    req = '0; stuck = 1'b0;
    repeat (2) @(negedge pclk);

    // short pulse between samples does nothing; drop after grant still completes
    @(negedge pclk);
    req[1] = 1'b1;
    #2 req[1] = 1'b0;
    saw = 1'b0;
    repeat (4) begin
      @(negedge pclk);
      if (psel) saw = 1'b1;
    end
    chk("t6_pulse_no_psel", 32'(saw), 32'd0);
    set_req(1, 1'b0, 8'h66, 8'h00);
    wait_n = 3;
    push_exp(1, 0, 8'h66, 8'h00, 8'hD3, 0, 4, 0);
    req[1] = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 20 && !saw; k++) begin
      @(negedge pclk);
      if (psel) saw = 1'b1;
    end
    chk("t6_granted", 32'(saw), 32'd1);
    req[1] = 1'b0;
    wait_done("t6_drop_after_gnt");
    wait_n = 0;
    repeat (2) @(negedge pclk);

    // async reset mid-ACCESS, then rr restarts from 0
    set_req(2, 1'b0, 8'h70, 8'h00);
    stuck = 1'b1;
    req = 4'b0100;
    saw = 1'b0;
    for (int k = 0; k < 20 && !saw; k++) begin
      @(negedge pclk);
      if (penable) saw = 1'b1;
    end
    chk("t5_reached_access", 32'(saw), 32'd1);
    repeat (2) @(negedge pclk);
    #2 presetn = 1'b0;
    req = '0;
    #1 chk("t5_async_clear", 32'({psel, penable, busy, gnt, done}), 32'd0);
    @(negedge pclk);
    presetn = 1'b1; stuck = 1'b0;
    repeat (3) @(negedge pclk);
    set_req(1, 1'b0, 8'h11, 8'h00);
    set_req(3, 1'b0, 8'h33, 8'h00);
    push_exp(1, 0, 8'h11, 8'h00, 8'hA4, 0, 1, 0);
    push_exp(3, 0, 8'h33, 8'h00, 8'h86, 0, 1, 4);
    req = 4'b1010;
    wait_done("t5_first");
    req[1] = 1'b0;
    wait_done("t5_second");
    req[3] = 1'b0;

    repeat (5) @(negedge pclk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
